// File: rtl/bit_data_mem_if.sv
// Data-port bundle between the bit-serial core (master) and bit_data_mem (slave).
// Ports: D_A bit address, D_OE/D_WE load/store requests, D_O store bit,
//        D_I loaded bit, D_RDY access-complete strobe.
interface bit_data_mem_if #(
  parameter int DA_W = 12
);
  logic [DA_W-1:0] D_A;
  logic            D_OE;
  logic            D_WE;
  logic            D_O;
  logic            D_I;
  logic            D_RDY;

  modport master (
    output D_A, D_OE, D_WE, D_O,
    input  D_I, D_RDY
  );

  modport slave (
    input  D_A, D_OE, D_WE, D_O,
    output D_I, D_RDY
  );
endinterface

// File: rtl/bit_data_mem.sv
// Single-bit load/store responder: input image, output image and byte-wide marker RAM (read-modify-write).
// Latency: request seen in IDLE at cycle n, D_RDY high in cycle n+2+WAIT_CYC; D_I registered, held until next load.
// Backpressure: core stalls on D_RDY; dropping the request before the ACC edge aborts with no side effects.
// Ports: CLK, CLR (async active-high), bus (slave modport of bit_data_mem_if),
//        IN_PINS (async plant inputs), OUT_PINS (registered output image), ERR (sticky protocol error).
module bit_data_mem #(
  parameter int DA_W     = 12,
  parameter int IN_N     = 16,
  parameter int OUT_N    = 16,
  parameter int WAIT_CYC = 0
) (
  input  logic               CLK,
  input  logic               CLR,
  bit_data_mem_if.slave      bus,
  input  logic [IN_N-1:0]    IN_PINS,
  output logic [OUT_N-1:0]   OUT_PINS,
  output logic               ERR
);

  localparam int WORDS  = 1 << (DA_W - 3);
  localparam int IN_IW  = (IN_N > 1) ? $clog2(IN_N) : 1;
  localparam int OUT_IW = (OUT_N > 1) ? $clog2(OUT_N) : 1;
  localparam logic [DA_W-1:0] OUT_BASE = DA_W'(IN_N);
  localparam logic [DA_W-1:0] RAM_BASE = DA_W'(IN_N + OUT_N);

  typedef enum logic [1:0] {IDLE, WAIT, ACC, ACK} state_t;

  state_t          state;
  logic            is_ld;
  logic [DA_W-1:0] addr_q;
  logic [1:0]      cnt;
  logic [IN_N-1:0] sync1;
  logic [IN_N-1:0] sync2;
  logic            di_q;

  logic [7:0]      mem [WORDS];
  logic [7:0]      rd_q;

  logic              req;
  logic              live;
  logic              in_rgn;
  logic              out_rgn;
  logic [IN_IW-1:0]  in_idx;
  logic [OUT_IW-1:0] out_idx;
  logic [2:0]        bit_idx;
  logic [7:0]        wr_dat;
  logic              ram_re;
  logic              ram_we;

  assign req     = bus.D_OE | bus.D_WE;
  // The request that was latched must still be present; a flush drops it.
  assign live    = is_ld ? bus.D_OE : bus.D_WE;
  assign in_rgn  = (addr_q < OUT_BASE);
  assign out_rgn = !in_rgn && (addr_q < RAM_BASE);
  assign in_idx  = addr_q[IN_IW-1:0];
  assign out_idx = OUT_IW'(addr_q - OUT_BASE);
  assign bit_idx = addr_q[2:0];

  // Merged word for the RMW store: the word read in IDLE with one bit replaced.
  always_comb begin
    wr_dat          = rd_q;
    wr_dat[bit_idx] = bus.D_O;
  end

  assign ram_re = (state == IDLE) && req;
  assign ram_we = (state == ACC) && !is_ld && live && !in_rgn && !out_rgn;

  // Marker RAM: synchronous read, no reset. The write enable derives from the
  // async-reset FSM, so a CLR can never leave a partial write behind.
  always_ff @(posedge CLK) begin
    if (ram_re) begin
      rd_q <= mem[bus.D_A[DA_W-1:3]];
    end
    if (ram_we) begin
      mem[addr_q[DA_W-1:3]] <= wr_dat;
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state    <= IDLE;
      is_ld    <= 1'b0;
      addr_q   <= '0;
      cnt      <= '0;
      sync1    <= '0;
      sync2    <= '0;
      di_q     <= 1'b0;
      OUT_PINS <= '0;
      ERR      <= 1'b0;
    end else begin
      sync1 <= IN_PINS;
      sync2 <= sync1;
      case (state)
        IDLE: begin
          if (req) begin
            // Simultaneous OE/WE is served as a load.
            is_ld  <= bus.D_OE;
            addr_q <= bus.D_A;
            cnt    <= 2'(WAIT_CYC);
            if (bus.D_OE && bus.D_WE) begin
              ERR <= 1'b1;
            end
            if (WAIT_CYC > 0) begin
              state <= WAIT;
            end else begin
              state <= ACC;
            end
          end
        end
        WAIT: begin
          if (!live) begin
            state <= IDLE;
          end else if (cnt <= 2'd1) begin
            state <= ACC;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        ACC: begin
          if (!live) begin
            state <= IDLE;
          end else begin
            if (is_ld) begin
              if (in_rgn) begin
                di_q <= sync2[in_idx];
              end else if (out_rgn) begin
                di_q <= OUT_PINS[out_idx];
              end else begin
                di_q <= rd_q[bit_idx];
              end
            end else if (out_rgn) begin
              OUT_PINS[out_idx] <= bus.D_O;
            end
            state <= ACK;
          end
        end
        ACK: begin
          // Unconditional: the request is still high this cycle and must not be re-served.
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.D_I   = di_q;
  assign bus.D_RDY = (state == ACK);

endmodule

// File: tb/tb_bit_data_mem.sv
module tb_bit_data_mem;
  localparam int DA_W  = 12;
  localparam int IN_N  = 16;
  localparam int OUT_N = 16;
  localparam int W     = 2;
  localparam int LAT   = 2 + W;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic [15:0] IN_PINS = '0;
  logic [15:0] OUT_PINS;
  logic        ERR;

  bit_data_mem_if #(.DA_W(DA_W)) bus ();

  bit_data_mem #(.DA_W(DA_W), .IN_N(IN_N), .OUT_N(OUT_N), .WAIT_CYC(W)) dut (
    .CLK(CLK), .CLR(CLR), .bus(bus), .IN_PINS(IN_PINS), .OUT_PINS(OUT_PINS), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Pin value seen at every rising edge, for the synchroniser-latency model.
  int          edge_cnt = 0;
  logic [15:0] pin_hist [int];
  always @(posedge CLK) begin
    edge_cnt = edge_cnt + 1;
    pin_hist[edge_cnt] = IN_PINS;
  end

  // Reference state
  logic [15:0] out_m = '0;
  bit          ram_m [int];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one request from a falling edge; returns the cycle index of D_RDY
  // (0 if none), the edge at which the access samples data, and the D_I seen.
  task automatic do_req(input bit ld, input bit st, input logic [11:0] a, input bit d,
                        input int drop_k, input int pin_k, input logic [15:0] pin_v,
                        output int rdy_k, output int e_acc, output logic di);
    bus.D_A = a; bus.D_OE = ld; bus.D_WE = st; bus.D_O = d;
    rdy_k = 0; di = 1'bx;
    e_acc = edge_cnt + 2 + W;
    for (int k = 1; k <= 3 * LAT + 4; k++) begin
      @(negedge CLK);
      if (k == pin_k) IN_PINS = pin_v;
      if (bus.D_RDY) begin
        rdy_k = k; di = bus.D_I;
        break;
      end
      if (k == drop_k) begin
        bus.D_OE = 1'b0; bus.D_WE = 1'b0;
      end
    end
    bus.D_OE = 1'b0; bus.D_WE = 1'b0;
    if (rdy_k != 0) begin
      @(negedge CLK);
      check("rdy_single_cycle", {31'd0, bus.D_RDY}, 32'd0);
      check("di_hold", {31'd0, bus.D_I}, {31'd0, di});
    end
  endtask

  task automatic st_op(input logic [11:0] a, input bit d);
    int rk, ea; logic di;
    do_req(1'b0, 1'b1, a, d, 0, 0, '0, rk, ea, di);
    check($sformatf("st_lat_%0h", a), rk, LAT);
    if (a >= IN_N && a < IN_N + OUT_N) begin
      out_m[a - IN_N] = d;
      check($sformatf("out_pins_%0h", a), {16'd0, OUT_PINS}, {16'd0, out_m});
    end else if (a >= IN_N + OUT_N) begin
      ram_m[int'(a)] = d;
    end
  endtask

  task automatic ld_op(input logic [11:0] a, input int pin_k, input logic [15:0] pin_v,
                       output logic di);
    int rk, ea; logic e; bit known;
    do_req(1'b1, 1'b0, a, 1'b0, 0, pin_k, pin_v, rk, ea, di);
    check($sformatf("ld_lat_%0h", a), rk, LAT);
    known = 1'b1; e = 1'bx;
    if (a < IN_N) e = pin_hist[ea - 2][a];
    else if (a < IN_N + OUT_N) e = out_m[a - IN_N];
    else if (ram_m.exists(int'(a))) e = ram_m[int'(a)];
    else known = 1'b0;
    if (known) check($sformatf("ld_val_%0h", a), {31'd0, di}, {31'd0, e});
  endtask

  initial begin
    int rk, ea, cnt;
    logic di, di_prev;
    logic [7:0] pat;
    logic [11:0] a;

    bus.D_A = '0; bus.D_OE = 1'b0; bus.D_WE = 1'b0; bus.D_O = 1'b0;
    #1;
    check("rst_rdy", {31'd0, bus.D_RDY}, 32'd0);
    check("rst_di", {31'd0, bus.D_I}, 32'd0);
    check("rst_out", {16'd0, OUT_PINS}, 32'd0);
    check("rst_err", {31'd0, ERR}, 32'd0);
    @(negedge CLK); @(negedge CLK);
    CLR = 1'b0;
    @(negedge CLK);

    // RAM round trip within byte 0x24
    pat = 8'($urandom) & 8'hF7;
    for (int i = 0; i < 8; i++) st_op(12'h120 + 12'(i), pat[i]);
    st_op(12'h123, 1'b1);
    ld_op(12'h123, 0, '0, di);
    check("ram_123", {31'd0, di}, 32'd1);
    for (int i = 0; i < 8; i++) ld_op(12'h120 + 12'(i), 0, '0, di);

    // Input region: a change arriving one edge before the access edge is too late
    ld_op(12'd5, W, 16'h0020, di);
    check("in_late", {31'd0, di}, 32'd0);
    repeat (4) @(negedge CLK);
    ld_op(12'd5, 0, '0, di);
    check("in_seen", {31'd0, di}, 32'd1);
    st_op(12'd5, 1'b0);
    ld_op(12'd5, 0, '0, di);
    check("in_store_ignored", {31'd0, di}, 32'd1);

    // Output region
    st_op(12'd19, 1'b1);
    check("out_0008", {16'd0, OUT_PINS}, 32'h0008);
    ld_op(12'd19, 0, '0, di);
    check("out_rd", {31'd0, di}, 32'd1);

    // Flush: store dropped in WAIT, then load dropped in ACC
    st_op(12'h200, 1'b0);
    do_req(1'b0, 1'b1, 12'h200, 1'b1, 1, 0, '0, rk, ea, di);
    check("flush_st_no_rdy", rk, 0);
    ld_op(12'h200, 0, '0, di);
    check("flush_st_lost", {31'd0, di}, 32'd0);
    ld_op(12'h123, 0, '0, di_prev);
    do_req(1'b1, 1'b0, 12'h200, 1'b0, 1 + W, 0, '0, rk, ea, di);
    check("flush_ld_no_rdy", rk, 0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (bus.D_RDY) cnt++;
    end
    check("flush_quiet", cnt, 0);
    check("flush_di_kept", {31'd0, bus.D_I}, {31'd0, di_prev});

    // Randomized mix over all regions
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 2) == 0) IN_PINS = 16'($urandom);
      case ($urandom_range(0, 2))
        0: a = 12'($urandom_range(0, IN_N - 1));
        1: a = 12'(IN_N + $urandom_range(0, OUT_N - 1));
        default: a = 12'h100 + 12'($urandom_range(0, 23));
      endcase
      if ($urandom_range(0, 1) == 0) st_op(a, 1'($urandom));
      else ld_op(a, $urandom_range(0, LAT), 16'($urandom), di);
    end

    // Protocol error: both strobes served as a load, ERR sticky
    st_op(12'h300, 1'b1);
    check("err_clear", {31'd0, ERR}, 32'd0);
    do_req(1'b1, 1'b1, 12'h300, 1'b0, 0, 0, '0, rk, ea, di);
    check("err_lat", rk, LAT);
    check("err_as_load", {31'd0, di}, 32'd1);
    check("err_set", {31'd0, ERR}, 32'd1);
    ld_op(12'h300, 0, '0, di);
    check("err_no_write", {31'd0, di}, 32'd1);
    check("err_sticky", {31'd0, ERR}, 32'd1);

    // CLR during WAIT of a store
    st_op(12'h301, 1'b0);
    st_op(12'd23, 1'b1);
    bus.D_A = 12'h301; bus.D_O = 1'b1; bus.D_WE = 1'b1;
    @(negedge CLK); @(negedge CLK);
    CLR = 1'b1;
    #1;
    check("clr_rdy", {31'd0, bus.D_RDY}, 32'd0);
    check("clr_out", {16'd0, OUT_PINS}, 32'd0);
    check("clr_err", {31'd0, ERR}, 32'd0);
    check("clr_di", {31'd0, bus.D_I}, 32'd0);
    bus.D_WE = 1'b0;
    @(negedge CLK);
    CLR = 1'b0;
    out_m = '0;
    @(negedge CLK);
    ld_op(12'h301, 0, '0, di);
    check("clr_store_lost", {31'd0, di}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/bit_data_mem.md
# bit_data_mem

Data-memory responder for the bit-serial logic core: serves the core's single-bit load (D_OE) and store (D_WE) requests on the D_A/D_I/D_O/D_RDY interface with a D_RDY stall handshake. The address space maps to a synchronised input image, a latched output image and a byte-wide internal marker RAM accessed by read-modify-write. It sits between the core's data port and the plant I/O pins.

## Interface
- DA_W, 12: data address width; must equal the core's DA_W.
- IN_N, 16: number of input-image bits, at addresses 0 .. IN_N-1.
- OUT_N, 16: number of output-image bits, at addresses IN_N .. IN_N+OUT_N-1.
- WAIT_CYC, 0: extra wait cycles per access, range 0..3, to model slow RAM.

- CLK  in  1  clock; all state changes on rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- D_A  in  DA_W  bit address; stable while a request is pending.
- D_OE  in  1  load request.
- D_WE  in  1  store request.
- D_O  in  1  bit to store; sampled with D_WE.
- D_I  out  1  loaded bit (registered); held until the next load completes.
- D_RDY  out  1  access complete; combinational from state.
- IN_PINS  in  IN_N  asynchronous plant inputs.
- OUT_PINS  out  OUT_N  output image (registered).
- ERR  out  1  sticky protocol error.

## Operation
- Address decode:
  - D_A < IN_N: input region.
  - D_A < IN_N+OUT_N: output region.
  - Otherwise: RAM bit. Word = D_A[DA_W-1:3], bit = D_A[2:0].
  - RAM holds 2^(DA_W-3) bytes with a synchronous read port. RAM words whose addresses fall in the I/O regions are unused.
- Input region:
  - IN_PINS pass through a 2-flop synchroniser.
  - Loads return the synchronised bit.
  - Stores are ignored but still acknowledged.
- Output region: loads read back OUT_PINS; stores update only the addressed bit.
- FSM states: IDLE, WAIT, ACC, ACK.
  - IDLE: if D_OE or D_WE is high, latch the request type and address, issue a RAM read of the word, load the wait counter with WAIT_CYC, then go to WAIT if WAIT_CYC>0, else ACC.
  - WAIT: decrement the counter; go to ACC when it reaches 1.
  - ACC, load: D_I <= selected bit (RAM word bit, synchronised input, or OUT_PINS bit).
  - ACC, store: write the merged word (RAM word with the bit replaced by D_O) to RAM, or update the OUT_PINS bit. Then go to ACK.
  - ACK: D_RDY=1; go to IDLE unconditionally, so the still-asserted request of the same instruction is never re-served.
- Abort: if the request type drops (pipe flush) in WAIT or ACC before the ACC edge, return to IDLE. Nothing is written and D_I is unchanged.
- D_OE and D_WE high together: serve as a load and set ERR. ERR clears only on CLR.
- RAM contents are not reset.

## Timing
- Reset values: D_I=0, D_RDY=0, OUT_PINS=0, ERR=0, FSM=IDLE, synchroniser=0.
- Load and store latency: the request is seen in IDLE at cycle n; D_RDY=1 in cycle n+2+WAIT_CYC.
- D_I is valid from the ACK cycle onward and stays stable at least through the following cycle, which is the core's execute stage.
- Minimum request spacing: 3+WAIT_CYC cycles; IDLE is re-entered the cycle after ACK.
- D_RDY is low in IDLE, WAIT and ACC, and high only in ACK.
- Store-then-load to the same bit returns the new value, because the write commits at the ACC edge before the next IDLE.
- Input latency: a pin change is visible to loads 2 cycles after the change is sampled.
- CLR mid-access: asynchronous return to IDLE with the reset values above. A store not yet at its ACC edge is lost; a partial RAM write never occurs.

## Test plan
- Reset: assert CLR during a WAIT state with WAIT_CYC=2 -> D_RDY=0, OUT_PINS=0, ERR=0 immediately; the next request gets its full latency.
- RAM round trip: store D_O=1 to 0x123, then load 0x123 and 0x122 -> D_RDY pulses in cycle n+2 of each request; D_I=1 then 0; the other bits of byte 0x24 are unchanged.
- Input region: IN_PINS[5] 0->1, then load address 5 (a) one cycle after and (b) four cycles after -> (a) D_I=0, (b) D_I=1; a store to address 5 is acknowledged and a reload still returns the pin.
- Output region: store 1 to address 16+3 -> OUT_PINS=0x0008 after the ACC edge; load 19 -> D_I=1.
- Flush abort: D_WE to 0x200 with D_O=1, dropped in the cycle after IDLE with WAIT_CYC=1 -> no D_RDY; a load of 0x200 returns the prior value.
- Protocol error: D_OE=D_WE=1 at address 0x300 -> served as a load, ERR=1 and remains 1 across later requests until CLR.
